// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers and lane-vector conventions for the adder tree and its front ends.
// Lane vectors are packed as [0:N-1][W-1:0], so lane 0 sits in the most significant bits.
package adder_tree_pkg;

  localparam int unsigned DEF_DATA_W = 5;
  localparam int unsigned DEF_DATA_N = 7;

  // Lane-vector layout at the default configuration
  typedef logic [0:DEF_DATA_N-1][DEF_DATA_W-1:0] def_lane_vec_t;

  // Width of an index that can address n lanes (n >= 2)
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n);
  endfunction

  // Number of pairwise-add stages needed to reduce n lanes to one
  function automatic int unsigned stages_n(input int unsigned n);
    return $clog2(n);
  endfunction

  // Width of the full sum of n lanes of w bits each
  function automatic int unsigned sum_width(input int unsigned w, input int unsigned n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/vec_hold_reg.sv
// Valid/ready output register. It loads a new vector when told to, and otherwise holds
// its contents. out_free says whether a load is allowed this cycle. data is kept after a
// handshake so the last vector remains visible.
module vec_hold_reg #(
  parameter int unsigned WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             out_free
);

  assign out_free = !valid || ready;

  // Load takes priority; otherwise a handshake empties the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_vec_packer.sv
// Collects DATA_N stream words into one packed frame for adder_tree_bin.
// There is a fill buffer plus an output register, so input can keep running while a frame
// waits downstream. Optional macro PACKER_FLUSH_EN adds s_last, which closes a frame early
// and zero-fills the remaining lanes.
module stream_vec_packer
  import adder_tree_pkg::*;
#(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned DATA_N = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  input  logic [DATA_W-1:0]              s_data,
`ifdef PACKER_FLUSH_EN
  input  logic                           s_last,
`endif
  output logic                           s_ready,
  output logic                           m_valid,
  output logic [0:DATA_N-1][DATA_W-1:0]  m_data,
  input  logic                           m_ready
);

  localparam int unsigned      IDX_W    = idx_width(DATA_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_N - 1);

  typedef logic [0:DATA_N-1][DATA_W-1:0] lane_vec_t;

  lane_vec_t        fill_q;
  lane_vec_t        frame_d;
  lane_vec_t        load_data;
  logic [IDX_W-1:0] idx_q;
  logic             buf_full_q;
  logic             accept;
  logic             close;
  logic             complete;
  logic             out_free;
  logic             load;
  logic             flush_last;

`ifdef PACKER_FLUSH_EN
  assign flush_last = s_last;
`else
  assign flush_last = 1'b0;
`endif

  // s_ready depends only on flops, never on s_valid
  assign s_ready  = !buf_full_q;
  assign accept   = s_valid && s_ready;
  assign close    = (idx_q == LAST_IDX) || flush_last;
  assign complete = accept && close;

  // Completed frame: lanes below idx from the buffer, the incoming word at idx, zeros above
  always_comb begin
    frame_d = fill_q;
    for (int i = 0; i < DATA_N; i++) begin
      if (IDX_W'(i) == idx_q) begin
        frame_d[i] = s_data;
      end else if (IDX_W'(i) > idx_q) begin
        frame_d[i] = '0;
      end
    end
  end

  // A parked full buffer goes out first. A buffer that is not full can only be bypassed
  // by the frame that completes in this cycle.
  assign load      = buf_full_q ? out_free : (complete && out_free);
  assign load_data = buf_full_q ? fill_q : frame_d;

  // Fill index, fill buffer and parked-frame flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      fill_q     <= '0;
      buf_full_q <= 1'b0;
    end else if (accept) begin
      if (close) begin
        idx_q <= '0;
        if (!out_free) begin
          fill_q     <= frame_d;
          buf_full_q <= 1'b1;
        end
      end else begin
        idx_q         <= idx_q + 1'b1;
        fill_q[idx_q] <= s_data;
      end
    end else if (buf_full_q && out_free) begin
      buf_full_q <= 1'b0;
    end
  end

  vec_hold_reg #(
    .WIDTH (DATA_W * DATA_N)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .ready     (m_ready),
    .valid     (m_valid),
    .data      (m_data),
    .out_free  (out_free)
  );

endmodule

// File: tb/tb_stream_vec_packer.sv
// Self-checking bench for stream_vec_packer: directed scenarios followed by random traffic.
// The model keeps the frames the DUT holds (output register plus parked buffer) as a queue.
module tb_stream_vec_packer;

  localparam int unsigned DATA_W = 5;
  localparam int unsigned DATA_N = 7;
`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef logic [0:DATA_N-1][DATA_W-1:0] frame_t;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              m_valid;
  frame_t            m_data;
  logic              m_ready;

  stream_vec_packer #(
    .DATA_W (DATA_W),
    .DATA_N (DATA_N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
`ifdef PACKER_FLUSH_EN
    .s_last  (s_last),
`endif
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  frame_t q[$];
  frame_t last_out;
  frame_t part;
  int     pidx;

  function automatic void model_reset();
    q.delete();
    last_out = '0;
    part     = '0;
    pidx     = 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    frame_t exp_data;
    exp_data = (q.size() > 0) ? q[0] : last_out;
    check("m_valid", 64'(m_valid), 64'(q.size() > 0));
    check("s_ready", 64'(s_ready), 64'(q.size() < 2));
    check("m_data", 64'(m_data), 64'(exp_data));
  endtask

  // One clock: drive inputs, step the model across the edge, compare just after the edge
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit mr);
    bit acc;
    bit hs;
    bit closes;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    m_ready = mr;
    acc     = v && (q.size() < 2);
    hs      = (q.size() > 0) && mr;
    @(posedge clk);
    if (hs) last_out = q.pop_front();
    if (acc) begin
      part[pidx] = d;
      closes = (pidx == DATA_N - 1) || (l && FLUSH);
      if (closes) begin
        for (int j = pidx + 1; j < DATA_N; j++) part[j] = '0;
        q.push_back(part);
        part = '0;
        pidx = 0;
      end else begin
        pidx++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int     sum;
    frame_t exp_f;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    model_reset();
    #3;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Words 1..7, downstream always ready; the tree sum of the frame is 28
    for (int i = 1; i <= 7; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1);
    check("first_valid", 64'(m_valid), 64'd1);
    sum = 0;
    for (int i = 0; i < DATA_N; i++) sum += int'(m_data[i]);
    check("first_sum", 64'(sum), 64'd28);

    // 21 words back to back: one frame every 7 cycles, s_ready stays high
    for (int i = 0; i < 21; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b1);
    drain();

    // Stall over two frames, then release for a single cycle
    for (int i = 1; i <= 14; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0);
    check("stall_s_ready", 64'(s_ready), 64'd0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("stall_lane0", 64'(m_data[0]), 64'd8);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("stall_ready_back", 64'(s_ready), 64'd1);
    drain();

    // Handshake in the same cycle as the next frame's last word: no bubble
    for (int i = 0; i < 7; i++) cycle(1'b1, DATA_W'(i + 3), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, DATA_W'(i + 20), 1'b0, 1'b0);
    cycle(1'b1, 5'd31, 1'b0, 1'b1);
    check("swap_valid", 64'(m_valid), 64'd1);
    check("swap_lane6", 64'(m_data[6]), 64'd31);
    drain();

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(i + 1), 1'b0, 1'b1);
    cycle(1'b1, 5'd4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, DATA_W'(i + 5), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'(i + 1), 1'b0, 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_m_data", 64'(m_data), 64'd0);
    check("arst_s_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 10; i <= 16; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1);
    check("arst_lane0", 64'(m_data[0]), 64'd10);
    drain();

`ifdef PACKER_FLUSH_EN
    // Early close on s_last, then a normal full frame
    cycle(1'b1, 5'd3, 1'b0, 1'b1);
    cycle(1'b1, 5'd4, 1'b0, 1'b1);
    cycle(1'b1, 5'd5, 1'b1, 1'b1);
    exp_f    = '0;
    exp_f[0] = 5'd3;
    exp_f[1] = 5'd4;
    exp_f[2] = 5'd5;
    check("flush_frame", 64'(m_data), 64'(exp_f));
    for (int i = 0; i < 7; i++) cycle(1'b1, DATA_W'(i + 9), 1'b0, 1'b1);
    check("flush_next_lane0", 64'(m_data[0]), 64'd9);
    drain();
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
